// File: rtl/frida_spi_pkg.sv
// -----------------------------------------------------------------------------
// frida_spi_pkg
// Shared definitions for the FRIDA SPI configuration path. FRAME_BITS is the
// single source of truth for the frame length and must match the width of the
// upstream SPI shift register.
// -----------------------------------------------------------------------------
package frida_spi_pkg;

    // Frame length in bits, shared with the shift register.
    localparam int FRAME_BITS = 180;

    // Width of the per-frame SCLK edge counter (must hold FRAME_BITS).
    localparam int CNT_W = 8;

    // Frame-level FSM: IDLE (cnt=0), SHIFT (1..FRAME_BITS-1),
    // DONE (cnt=FRAME_BITS, committed), OVR (extra edges seen after DONE).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        OVR   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/spi_frame_rst.sv
// -----------------------------------------------------------------------------
// spi_frame_rst
// Builds the active-high frame-level clear from the chip reset and the SPI
// chip select. A single OR gate keeps the clear glitch-free; the module is
// kept separate so a dont_touch constraint can be attached to it.
//
// Ports:
//   rst_b     in   asynchronous active-low chip reset
//   spi_cs_b  in   SPI chip select, active low
//   frame_clr out  active-high asynchronous clear for frame-level state
// -----------------------------------------------------------------------------
module spi_frame_rst (
    input  logic rst_b,
    input  logic spi_cs_b,
    output logic frame_clr
);

    assign frame_clr = ~rst_b | spi_cs_b;

endmodule

// File: rtl/spi_frame_commit.sv
// -----------------------------------------------------------------------------
// spi_frame_commit
// Counts SPI clock edges while chip select is active and, on exactly the
// FRAME_BITS-th rising edge, copies the completed frame into the shadow
// configuration register that drives the ADC. Short frames leave the shadow
// untouched; over-length frames keep the earlier commit and raise a sticky
// flag plus a saturating error count. Every commit inverts cfg_toggle so the
// ADC clock domain can detect it through a two-flop synchroniser.
//
// Ports:
//   spi_sclk   in   SPI serial clock, all updates on the rising edge
//   rst_b      in   asynchronous active-low reset
//   spi_cs_b   in   SPI chip select, active low; high clears frame state
//   spi_sdi    in   serial data in (same net as the shift register input)
//   spi_bits   in   parallel shift-register contents
//   cfg_bits   out  committed configuration
//   cfg_toggle out  inverts on every commit
//   frame_ovr  out  sticky: last frame was longer than FRAME_BITS
//   ovr_cnt    out  saturating count of over-length frames
//   commit_cnt out  wrapping count of commits
// -----------------------------------------------------------------------------
module spi_frame_commit #(
    parameter int FRAME_BITS = frida_spi_pkg::FRAME_BITS,
    parameter int ERR_W      = 4
) (
    input  logic                  spi_sclk,
    input  logic                  rst_b,
    input  logic                  spi_cs_b,
    input  logic                  spi_sdi,
    input  logic [FRAME_BITS-1:0] spi_bits,
    output logic [FRAME_BITS-1:0] cfg_bits,
    output logic                  cfg_toggle,
    output logic                  frame_ovr,
    output logic [ERR_W-1:0]      ovr_cnt,
    output logic [7:0]            commit_cnt
);

    import frida_spi_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    logic             frame_clr;
    frame_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             commit_now;
    logic             enter_ovr;

    // The MSB of the shift register falls off the end on the committing edge.
    logic unused_msb;
    assign unused_msb = spi_bits[FRAME_BITS-1];

    spi_frame_rst u_frame_rst (
        .rst_b     (rst_b),
        .spi_cs_b  (spi_cs_b),
        .frame_clr (frame_clr)
    );

    // Frame state is held in IDLE by frame_clr, so these are only true on
    // edges inside an active frame.
    assign commit_now = (state == SHIFT) && (cnt == LAST_CNT);
    assign enter_ovr  = (state == DONE);

    // Frame-level FSM and edge counter. The counter freezes at FRAME_BITS
    // once the frame is done; OVR is sticky until chip select rises.
    always_ff @(posedge spi_sclk or posedge frame_clr) begin
        if (frame_clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= SHIFT;
                    cnt   <= CNT_W'(1);
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= OVR;
                default: state <= OVR;
            endcase
        end
    end

    // Committed state survives chip select and is cleared by rst_b only.
    // The shadow captures the shift register's post-edge value, i.e. the
    // current contents shifted by one with the incoming bit appended.
    always_ff @(posedge spi_sclk or negedge rst_b) begin
        if (!rst_b) begin
            cfg_bits   <= '0;
            cfg_toggle <= 1'b0;
            frame_ovr  <= 1'b0;
            ovr_cnt    <= '0;
            commit_cnt <= '0;
        end else if (commit_now) begin
            cfg_bits   <= {spi_bits[FRAME_BITS-2:0], spi_sdi};
            cfg_toggle <= ~cfg_toggle;
            commit_cnt <= commit_cnt + 8'd1;
            frame_ovr  <= 1'b0;
        end else if (enter_ovr) begin
            frame_ovr <= 1'b1;
            if (ovr_cnt != {ERR_W{1'b1}}) begin
                ovr_cnt <= ovr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_commit.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_commit
// Drives SPI frames into spi_frame_commit alongside a behavioural shift
// register, predicts the committed outputs per frame and compares them.
// -----------------------------------------------------------------------------
module tb_spi_frame_commit;

    localparam int FB = 180;

    logic          spi_sclk = 1'b0;
    logic          rst_b;
    logic          spi_cs_b;
    logic          spi_sdi;
    logic [FB-1:0] spi_bits;
    logic [FB-1:0] cfg_bits;
    logic          cfg_toggle;
    logic          frame_ovr;
    logic [3:0]    ovr_cnt;
    logic [7:0]    commit_cnt;

    typedef struct {
        logic [FB-1:0] cfg;
        logic          tog;
        logic [7:0]    cc;
        logic          ovr;
        logic [3:0]    oc;
    } exp_t;

    exp_t sb[$];

    // Reference model of the committed state.
    logic [FB-1:0] m_cfg;
    logic          m_tog;
    logic [7:0]    m_cc;
    logic          m_ovr;
    logic [3:0]    m_oc;

    int n_checks = 0;
    int n_pass   = 0;

    spi_frame_commit #(.FRAME_BITS(FB), .ERR_W(4)) dut (
        .spi_sclk   (spi_sclk),
        .rst_b      (rst_b),
        .spi_cs_b   (spi_cs_b),
        .spi_sdi    (spi_sdi),
        .spi_bits   (spi_bits),
        .cfg_bits   (cfg_bits),
        .cfg_toggle (cfg_toggle),
        .frame_ovr  (frame_ovr),
        .ovr_cnt    (ovr_cnt),
        .commit_cnt (commit_cnt)
    );

    always #5 spi_sclk = ~spi_sclk;

    // Behavioural upstream shift register.
    always @(posedge spi_sclk or negedge rst_b) begin
        if (!rst_b)        spi_bits <= '0;
        else if (!spi_cs_b) spi_bits <= {spi_bits[FB-2:0], spi_sdi};
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        m_cfg = '0; m_tog = 1'b0; m_cc = '0; m_ovr = 1'b0; m_oc = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge spi_sclk);
        rst_b = 1'b0; spi_cs_b = 1'b1; spi_sdi = 1'b0;
        model_reset();
        @(negedge spi_sclk);
        rst_b = 1'b1;
        @(negedge spi_sclk);
    endtask

    // Sends one frame of nbits (0xA5 pattern or random), updates the model,
    // pushes the predicted outputs and ends with chip select high.
    // Captures a few outputs right after edges FB and FB+1.
    task automatic send_frame(input int nbits, input bit rnd,
                              output logic tog_e180, output logic ovr_e180,
                              output logic ovr_e181);
        logic [7:0]    pat;
        logic [FB-1:0] frame;
        logic          b;
        exp_t          e;
        pat = 8'hA5;
        frame = '0;
        tog_e180 = 1'bx; ovr_e180 = 1'bx; ovr_e181 = 1'bx;
        @(negedge spi_sclk);
        spi_cs_b = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = rnd ? 1'($urandom_range(0, 1)) : pat[7 - (i % 8)];
            spi_sdi = b;
            if (i < FB) frame = {frame[FB-2:0], b};
            @(posedge spi_sclk);
            #1;
            if (i == FB - 1) begin tog_e180 = cfg_toggle; ovr_e180 = frame_ovr; end
            if (i == FB)     ovr_e181 = frame_ovr;
            @(negedge spi_sclk);
        end
        spi_cs_b = 1'b1;
        if (nbits >= FB) begin
            m_cfg = frame; m_tog = ~m_tog; m_cc = m_cc + 8'd1; m_ovr = 1'b0;
        end
        if (nbits > FB) begin
            m_ovr = 1'b1;
            if (m_oc != 4'hF) m_oc = m_oc + 4'd1;
        end
        e.cfg = m_cfg; e.tog = m_tog; e.cc = m_cc; e.ovr = m_ovr; e.oc = m_oc;
        sb.push_back(e);
        @(negedge spi_sclk);
    endtask

    task automatic test_reset();
        rst_b = 1'b0; spi_cs_b = 1'b1; spi_sdi = 1'b0;
        model_reset();
        #12;
        n_checks++; if (cfg_bits !== '0) $display("[TB] FAIL reset cfg_bits: got %h expected 0", cfg_bits); else n_pass++;
        n_checks++; if (cfg_toggle !== 1'b0) $display("[TB] FAIL reset cfg_toggle: got %b expected 0", cfg_toggle); else n_pass++;
        n_checks++; if (frame_ovr !== 1'b0) $display("[TB] FAIL reset frame_ovr: got %b expected 0", frame_ovr); else n_pass++;
        n_checks++; if (ovr_cnt !== 4'd0) $display("[TB] FAIL reset ovr_cnt: got %0d expected 0", ovr_cnt); else n_pass++;
        n_checks++; if (commit_cnt !== 8'd0) $display("[TB] FAIL reset commit_cnt: got %0d expected 0", commit_cnt); else n_pass++;
        @(negedge spi_sclk);
        rst_b = 1'b1;
        @(negedge spi_sclk);
    endtask

    task automatic test_full_frame();
        logic t, o, o2;
        exp_t e;
        logic [FB-1:0] a5;
        for (int i = 0; i < FB / 8 + 1; i++) a5 = {a5[FB-9:0], 8'hA5};
        // 180 bits of repeated A5 end on a half byte: keep the low 180 bits
        // of A5 repeated ending in ...A, i.e. pattern shifted right by 4.
        a5 = {a5[FB-5:0], 4'hA} >> 0;
        send_frame(FB, 1'b0, t, o, o2);
        e = sb.pop_front();
        n_checks++; if (cfg_bits !== e.cfg) $display("[TB] FAIL full cfg_bits: got %h expected %h", cfg_bits, e.cfg); else n_pass++;
        n_checks++; if (cfg_bits !== a5) $display("[TB] FAIL full a5 pattern: got %h expected %h", cfg_bits, a5); else n_pass++;
        n_checks++; if (t !== 1'b1) $display("[TB] FAIL full toggle at edge 180: got %b expected 1", t); else n_pass++;
        n_checks++; if (commit_cnt !== e.cc) $display("[TB] FAIL full commit_cnt: got %0d expected %0d", commit_cnt, e.cc); else n_pass++;
        n_checks++; if (frame_ovr !== e.ovr) $display("[TB] FAIL full frame_ovr: got %b expected %b", frame_ovr, e.ovr); else n_pass++;
    endtask

    task automatic test_short_frame();
        logic t, o, o2;
        exp_t e;
        send_frame(100, 1'b1, t, o, o2);
        e = sb.pop_front();
        n_checks++; if (cfg_bits !== e.cfg) $display("[TB] FAIL short cfg_bits: got %h expected %h", cfg_bits, e.cfg); else n_pass++;
        n_checks++; if (cfg_toggle !== e.tog) $display("[TB] FAIL short cfg_toggle: got %b expected %b", cfg_toggle, e.tog); else n_pass++;
        n_checks++; if (commit_cnt !== e.cc) $display("[TB] FAIL short commit_cnt: got %0d expected %0d", commit_cnt, e.cc); else n_pass++;
        send_frame(FB, 1'b1, t, o, o2);
        e = sb.pop_front();
        n_checks++; if (cfg_bits !== e.cfg) $display("[TB] FAIL after-short cfg_bits: got %h expected %h", cfg_bits, e.cfg); else n_pass++;
        n_checks++; if (cfg_toggle !== e.tog) $display("[TB] FAIL after-short cfg_toggle: got %b expected %b", cfg_toggle, e.tog); else n_pass++;
        n_checks++; if (commit_cnt !== e.cc) $display("[TB] FAIL after-short commit_cnt: got %0d expected %0d", commit_cnt, e.cc); else n_pass++;
    endtask

    task automatic test_overlength();
        logic t, o, o2;
        exp_t e;
        send_frame(FB + 3, 1'b1, t, o, o2);
        e = sb.pop_front();
        n_checks++; if (t !== e.tog) $display("[TB] FAIL ovr toggle at edge 180: got %b expected %b", t, e.tog); else n_pass++;
        n_checks++; if (o !== 1'b0) $display("[TB] FAIL ovr flag at edge 180: got %b expected 0", o); else n_pass++;
        n_checks++; if (o2 !== 1'b1) $display("[TB] FAIL ovr flag at edge 181: got %b expected 1", o2); else n_pass++;
        n_checks++; if (cfg_bits !== e.cfg) $display("[TB] FAIL ovr cfg_bits: got %h expected %h", cfg_bits, e.cfg); else n_pass++;
        n_checks++; if (ovr_cnt !== e.oc) $display("[TB] FAIL ovr ovr_cnt: got %0d expected %0d", ovr_cnt, e.oc); else n_pass++;
        n_checks++; if (frame_ovr !== e.ovr) $display("[TB] FAIL ovr frame_ovr: got %b expected %b", frame_ovr, e.ovr); else n_pass++;
    endtask

    task automatic test_saturation();
        logic t, o, o2;
        exp_t e;
        for (int k = 0; k < 20; k++) begin
            send_frame(FB + 1 + (k % 3), 1'b1, t, o, o2);
            e = sb.pop_front();
            n_checks++; if (ovr_cnt !== e.oc) $display("[TB] FAIL sat ovr_cnt frame %0d: got %0d expected %0d", k, ovr_cnt, e.oc); else n_pass++;
        end
        n_checks++; if (ovr_cnt !== 4'd15) $display("[TB] FAIL sat ovr_cnt final: got %0d expected 15", ovr_cnt); else n_pass++;
        send_frame(FB, 1'b1, t, o, o2);
        e = sb.pop_front();
        n_checks++; if (frame_ovr !== e.ovr) $display("[TB] FAIL sat good frame_ovr: got %b expected %b", frame_ovr, e.ovr); else n_pass++;
        n_checks++; if (ovr_cnt !== e.oc) $display("[TB] FAIL sat good ovr_cnt: got %0d expected %0d", ovr_cnt, e.oc); else n_pass++;
        n_checks++; if (cfg_bits !== e.cfg) $display("[TB] FAIL sat good cfg_bits: got %h expected %h", cfg_bits, e.cfg); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic t, o, o2;
        exp_t e;
        @(negedge spi_sclk);
        spi_cs_b = 1'b0;
        for (int i = 0; i < 90; i++) begin
            spi_sdi = 1'($urandom_range(0, 1));
            @(posedge spi_sclk);
            @(negedge spi_sclk);
        end
        rst_b = 1'b0;
        model_reset();
        #1;
        n_checks++; if (cfg_bits !== '0) $display("[TB] FAIL midrst cfg_bits: got %h expected 0", cfg_bits); else n_pass++;
        n_checks++; if (cfg_toggle !== 1'b0) $display("[TB] FAIL midrst cfg_toggle: got %b expected 0", cfg_toggle); else n_pass++;
        n_checks++; if (frame_ovr !== 1'b0) $display("[TB] FAIL midrst frame_ovr: got %b expected 0", frame_ovr); else n_pass++;
        n_checks++; if (ovr_cnt !== 4'd0) $display("[TB] FAIL midrst ovr_cnt: got %0d expected 0", ovr_cnt); else n_pass++;
        n_checks++; if (commit_cnt !== 8'd0) $display("[TB] FAIL midrst commit_cnt: got %0d expected 0", commit_cnt); else n_pass++;
        @(negedge spi_sclk);
        rst_b = 1'b1; spi_cs_b = 1'b1;
        @(negedge spi_sclk);
        send_frame(FB, 1'b1, t, o, o2);
        e = sb.pop_front();
        n_checks++; if (commit_cnt !== 8'd1) $display("[TB] FAIL midrst next commit_cnt: got %0d expected 1", commit_cnt); else n_pass++;
        n_checks++; if (cfg_bits !== e.cfg) $display("[TB] FAIL midrst next cfg_bits: got %h expected %h", cfg_bits, e.cfg); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic t, o, o2;
        exp_t e;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            send_frame(FB, 1'b1, t, o, o2);
            e = sb.pop_front();
            n_checks++; if (commit_cnt !== e.cc || cfg_toggle !== e.tog || cfg_bits !== e.cfg)
                $display("[TB] FAIL b2b frame %0d: got cc=%0d tog=%b expected cc=%0d tog=%b", k, commit_cnt, cfg_toggle, e.cc, e.tog);
            else n_pass++;
        end
        n_checks++; if (commit_cnt !== 8'd0) $display("[TB] FAIL wrap commit_cnt: got %0d expected 0", commit_cnt); else n_pass++;
        n_checks++; if (cfg_toggle !== 1'b0) $display("[TB] FAIL wrap cfg_toggle: got %b expected 0", cfg_toggle); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_overlength();
        test_saturation();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
